boot_loader: RTL

Bus initiator that fills the writable upper half of the boot ROM (words 0x8–0xF) from a byte stream, then reads the region back and checks it against a transmitted checksum. It sits between the byte-wide serial front end and the boot ROM's cs/we/addr/din/dout port. It drives that port only while the CPU is held off by `busy`.

---
 rtl/boot_loader_pkg.sv | 37 +++
 rtl/boot_loader_byte_sum8.sv | 22 ++
 rtl/boot_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/boot_loader_pkg.sv
// rtl/boot_loader_pkg.sv - state codes, error codes and state decode helpers for boot_loader
package boot_loader_pkg;

   typedef logic [3:0] state_t;

   localparam state_t S_IDLE      = 4'd0;
   localparam state_t S_RECV_HI   = 4'd1;
   localparam state_t S_RECV_LO   = 4'd2;
   localparam state_t S_WR_SETUP  = 4'd3;
   localparam state_t S_WR_STROBE = 4'd4;
   localparam state_t S_WR_HOLD   = 4'd5;
   localparam state_t S_RECV_CSUM = 4'd6;
   localparam state_t S_RD_ADDR   = 4'd7;
   localparam state_t S_RD_SAMPLE = 4'd8;
   localparam state_t S_DONE      = 4'd9;
   localparam state_t S_ERROR     = 4'd10;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_CSUM     = 2'd1;
   localparam logic [1:0] ERR_READBACK = 2'd2;

   // States in which the CPU owns the ROM port
   function automatic logic is_idle(input state_t s);
      return (s == S_IDLE) || (s == S_DONE) || (s == S_ERROR);
   endfunction

   // States in which a stream byte may be accepted
   function automatic logic is_recv(input state_t s);
      return (s == S_RECV_HI) || (s == S_RECV_LO) || (s == S_RECV_CSUM);
   endfunction

   // States in which the ROM is selected
   function automatic logic is_cs(input state_t s);
      return (s == S_WR_STROBE) || (s == S_RD_ADDR) || (s == S_RD_SAMPLE);
   endfunction

endpackage

// File: rtl/boot_loader_byte_sum8.sv
// rtl/boot_loader_byte_sum8.sv - 8-bit wrapping accumulator with clear and two-operand add
module byte_sum8 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] sum
);

   // Clear wins over add; the sum wraps modulo 256
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sum <= 8'h00;
      else if (clr)
         sum <= 8'h00;
      else if (en)
         sum <= sum + a + b;
   end

endmodule

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - loads the upper boot ROM words from a byte stream and verifies them by readback
module boot_loader
   import boot_loader_pkg::*;
#(
   parameter logic [3:0] BASE_ADDR = 4'h8,
   parameter int         NUM_WORDS = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        mem_cs,
   output logic        mem_we,
   output logic [3:0]  mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic        busy,
   output logic        done,
   output logic [1:0]  error
);

   localparam int            CW       = $clog2(NUM_WORDS + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(NUM_WORDS - 1);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [7:0]    csum;
   logic [7:0]    rx_sum;
   logic [7:0]    rd_sum;
   logic [7:0]    rd_total;
   logic          xfer;
   logic          last_word;
   logic          take_start;
   logic          rx_add;
   logic          rd_add;

   // Handshake and bookkeeping decodes from the registered state
   always_comb begin
      xfer       = byte_valid & byte_ready;
      last_word  = (cnt == LAST_CNT);
      take_start = start & is_idle(state);
      rx_add     = xfer & ((state == S_RECV_HI) | (state == S_RECV_LO));
      rd_add     = (state == S_RD_SAMPLE);
      rd_total   = rd_sum + mem_rdata[15:8] + mem_rdata[7:0];
   end

   byte_sum8 u_rx_sum (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (take_start),
      .en    (rx_add),
      .a     (byte_in),
      .b     (8'h00),
      .sum   (rx_sum)
   );

   byte_sum8 u_rd_sum (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (take_start),
      .en    (rd_add),
      .a     (mem_rdata[15:8]),
      .b     (mem_rdata[7:0]),
      .sum   (rd_sum)
   );

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_RECV_HI;
         S_RECV_HI:   if (xfer) state_nxt = S_RECV_LO;
         S_RECV_LO:   if (xfer) state_nxt = S_WR_SETUP;
         S_WR_SETUP:  state_nxt = S_WR_STROBE;
         S_WR_STROBE: state_nxt = S_WR_HOLD;
         S_WR_HOLD:   state_nxt = last_word ? S_RECV_CSUM : S_RECV_HI;
         S_RECV_CSUM: if (xfer) state_nxt = (byte_in == rx_sum) ? S_RD_ADDR : S_ERROR;
         S_RD_ADDR:   state_nxt = S_RD_SAMPLE;
         S_RD_SAMPLE: begin
            if (!last_word)
               state_nxt = S_RD_ADDR;
            else
               state_nxt = (rd_total == csum) ? S_DONE : S_ERROR;
         end
         default:     state_nxt = S_IDLE;
      endcase
   end

   // State, bus and status registers; strobes are flops decoded from the next state so they never glitch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         byte_ready <= 1'b0;
         mem_cs     <= 1'b0;
         mem_we     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= ERR_NONE;
         mem_addr   <= 4'h0;
         mem_wdata  <= 16'h0000;
         cnt        <= '0;
         csum       <= 8'h00;
      end else begin
         state      <= state_nxt;
         byte_ready <= is_recv(state_nxt);
         mem_cs     <= is_cs(state_nxt);
         mem_we     <= (state_nxt == S_WR_STROBE);
         busy       <= !is_idle(state_nxt);
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  done     <= 1'b0;
                  error    <= ERR_NONE;
                  cnt      <= '0;
                  mem_addr <= BASE_ADDR;
               end
            end
            S_RECV_HI: if (xfer) mem_wdata[15:8] <= byte_in;
            S_RECV_LO: if (xfer) mem_wdata[7:0]  <= byte_in;
            S_WR_HOLD: begin
               if (last_word) begin
                  cnt <= '0;
               end else begin
                  cnt      <= cnt + 1'b1;
                  mem_addr <= mem_addr + 4'd1;
               end
            end
            S_RECV_CSUM: begin
               if (xfer) begin
                  if (byte_in != rx_sum) begin
                     error <= ERR_CSUM;
                  end else begin
                     mem_addr <= BASE_ADDR;
                     csum     <= byte_in;
                  end
               end
            end
            S_RD_SAMPLE: begin
               if (last_word) begin
                  if (rd_total == csum)
                     done <= 1'b1;
                  else
                     error <= ERR_READBACK;
               end else begin
                  cnt      <= cnt + 1'b1;
                  mem_addr <= mem_addr + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
